// File: rtl/mmu_dcache_arb_pkg.sv
// Shared widths and state encoding for the dcache port arbiter.
package mmu_dcache_arb_pkg;
   localparam int XLEN   = 32;
   localparam int ADDR_W = XLEN;
   localparam int DATA_W = XLEN;
   localparam int SEL_W  = DATA_W / 8;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_PTW,
      ARB_LSU,
      ARB_DRAIN
   } type_arb_state_e;
endpackage

// File: rtl/mmu_dcache_arb_if.sv
// LSU, PTW and dcache request/response bundle around the arbiter.
interface mmu_dcache_arb_if;
   import mmu_dcache_arb_pkg::*;

   logic              lsu_req;
   logic              lsu_w_en;
   logic [ADDR_W-1:0] lsu_addr;
   logic [DATA_W-1:0] lsu_wdata;
   logic [SEL_W-1:0]  lsu_sel_byte;
   logic              lsu_ack;
   logic [DATA_W-1:0] lsu_rdata;

   logic              ptw_req;
   logic [ADDR_W-1:0] ptw_paddr;
   logic              ptw_kill;
   logic              ptw_r_valid;
   logic [DATA_W-1:0] ptw_rdata;

   logic              dcache_req;
   logic              dcache_w_en;
   logic [ADDR_W-1:0] dcache_addr;
   logic [DATA_W-1:0] dcache_wdata;
   logic [SEL_W-1:0]  dcache_sel_byte;
   logic              dcache_ack;
   logic [DATA_W-1:0] dcache_rdata;

   // master: the arbiter itself; slave: the LSU/PTW/dcache environment
   modport master (
      input  lsu_req, lsu_w_en, lsu_addr, lsu_wdata, lsu_sel_byte,
      input  ptw_req, ptw_paddr, ptw_kill,
      input  dcache_ack, dcache_rdata,
      output lsu_ack, lsu_rdata, ptw_r_valid, ptw_rdata,
      output dcache_req, dcache_w_en, dcache_addr, dcache_wdata, dcache_sel_byte
   );

   modport slave (
      output lsu_req, lsu_w_en, lsu_addr, lsu_wdata, lsu_sel_byte,
      output ptw_req, ptw_paddr, ptw_kill,
      output dcache_ack, dcache_rdata,
      input  lsu_ack, lsu_rdata, ptw_r_valid, ptw_rdata,
      input  dcache_req, dcache_w_en, dcache_addr, dcache_wdata, dcache_sel_byte
   );
endinterface

// File: rtl/mmu_dcache_arb_streak_cnt.sv
// Saturating count of consecutive PTW grants taken while the LSU waits.
module mmu_dcache_arb_streak_cnt #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_sat
);
   localparam int CNT_W = $clog2(MAX + 1);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != MAX_C)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_sat = (r_cnt == MAX_C);
endmodule

// File: rtl/mmu_dcache_arb.sv
// Single-outstanding arbiter for the dcache port: PTW priority, bounded LSU
// starvation, and silent draining of killed walks.
//
//   state     | meaning
//   ARB_IDLE  | no transaction outstanding, grant decision made here
//   ARB_PTW   | PTW read outstanding
//   ARB_LSU   | LSU load/store outstanding
//   ARB_DRAIN | killed PTW read outstanding, response will be discarded
module mmu_dcache_arb
   import mmu_dcache_arb_pkg::*;
#(
   parameter int MAX_PTW_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   mmu_dcache_arb_if.master  bus
);
   type_arb_state_e   r_state;
   logic              r_req;
   logic              r_w_en;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [SEL_W-1:0]  r_sel;

   logic w_idle;
   logic w_sat;
   logic w_grant_ptw;
   logic w_grant_lsu;

   assign w_idle      = (r_state == ARB_IDLE);
   assign w_grant_ptw = w_idle & bus.ptw_req & ~bus.ptw_kill & ~(bus.lsu_req & w_sat);
   assign w_grant_lsu = w_idle & bus.lsu_req & ~w_grant_ptw;

   mmu_dcache_arb_streak_cnt #(.MAX(MAX_PTW_STREAK)) u_streak (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_grant_ptw & bus.lsu_req),
      .i_clr (w_grant_lsu | (w_idle & ~bus.lsu_req)),
      .o_sat (w_sat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ARB_IDLE;
         r_req   <= 1'b0;
         r_w_en  <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_sel   <= '0;
      end else begin
         unique case (r_state)
            ARB_IDLE: begin
               if (w_grant_ptw) begin
                  r_state <= ARB_PTW;
                  r_req   <= 1'b1;
                  r_w_en  <= 1'b0;
                  r_addr  <= bus.ptw_paddr;
                  r_wdata <= '0;
                  r_sel   <= '1;
               end else if (w_grant_lsu) begin
                  r_state <= ARB_LSU;
                  r_req   <= 1'b1;
                  r_w_en  <= bus.lsu_w_en;
                  r_addr  <= bus.lsu_addr;
                  r_wdata <= bus.lsu_wdata;
                  r_sel   <= bus.lsu_sel_byte;
               end
            end
            // the cache cannot withdraw a request, so a kill only reroutes the response
            ARB_PTW: begin
               if (bus.dcache_ack) begin
                  r_state <= ARB_IDLE;
                  r_req   <= 1'b0;
               end else if (bus.ptw_kill) begin
                  r_state <= ARB_DRAIN;
               end
            end
            ARB_LSU, ARB_DRAIN: begin
               if (bus.dcache_ack) begin
                  r_state <= ARB_IDLE;
                  r_req   <= 1'b0;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   assign bus.dcache_req      = r_req;
   assign bus.dcache_w_en     = r_w_en;
   assign bus.dcache_addr     = r_addr;
   assign bus.dcache_wdata    = r_wdata;
   assign bus.dcache_sel_byte = r_sel;

   assign bus.ptw_r_valid = (r_state == ARB_PTW) & bus.dcache_ack & ~bus.ptw_kill;
   assign bus.lsu_ack     = (r_state == ARB_LSU) & bus.dcache_ack;
   assign bus.ptw_rdata   = bus.dcache_rdata;
   assign bus.lsu_rdata   = bus.dcache_rdata;

   a_lsu_hold: assert property (@(posedge clk) disable iff (rst)
      (r_state == ARB_LSU) |-> bus.lsu_req);
   a_ptw_hold: assert property (@(posedge clk) disable iff (rst)
      ((r_state == ARB_PTW) && !bus.ptw_kill) |-> bus.ptw_req);
   a_onehot: assert property (@(posedge clk) disable iff (rst)
      !(bus.lsu_ack && bus.ptw_r_valid));
endmodule
